pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the IF/ID boundary. It decides each cycle whether the PC advances, whether the IF/ID register holds, whether it is flushed to a NOP, and whether a bubble enters ID/EX. It arbitrates three competing events: load-use stalls, taken-branch redirects, and instruction-fetch wait states. It also keeps saturating stall and flush counters for performance measurement.

---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the IF/ID pipeline datapath and the
// hazard sequencer. The datapath side uses the master modport; the
// sequencer uses the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard sources presented by the pipeline
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_use_rs2_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rd_i;
    logic             branch_taken_i;
    logic             imem_ready_i;

    // Pipeline controls and status returned by the sequencer
    logic             pc_write_o;
    logic             ifid_hold_o;
    logic [1:0]       ifid_branch_o;
    logic             idex_bubble_o;
    logic             fetch_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
               branch_taken_i, imem_ready_i,
        input  pc_write_o, ifid_hold_o, ifid_branch_o, idex_bubble_o,
               fetch_err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs2_i, ex_memread_i, ex_rd_i,
               branch_taken_i, imem_ready_i,
        output pc_write_o, ifid_hold_o, ifid_branch_o, idex_bubble_o,
               fetch_err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID pipeline sequencer: arbitrates load-use stalls, taken-branch
// redirects and instruction-fetch wait states, and keeps saturating
// stall/flush performance counters plus a sticky fetch-timeout flag.
// Control outputs are Mealy so they act in the same cycle as the event.
module pipe_hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FETCH_TIMEOUT   = 64,
    parameter int CNT_W           = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LU_STALL   = 2'd1,
        ST_FETCH_WAIT = 2'd2
    } state_e;

    // Load-use counter only needs to hold LOAD_USE_CYCLES-1 (at most 2)
    localparam int                LU_W     = 2;
    localparam logic [LU_W-1:0]   LU_INIT  = LU_W'(LOAD_USE_CYCLES - 1);
    localparam int                WAIT_W   = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(FETCH_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic lu_hit;
    logic ev_stall;
    logic ev_flush;
    logic ev_wait;

    // A load in EX feeding a source register of the instruction in ID;
    // x0 is never a real dependency.
    assign lu_hit = bus.ex_memread_i
                  & (bus.ex_rd_i != 5'd0)
                  & ((bus.ex_rd_i == bus.id_rs1_i)
                     | (bus.id_use_rs2_i & (bus.ex_rd_i == bus.id_rs2_i)));

    // Classify this cycle: load-use stall beats branch beats fetch wait.
    // Branches are ignored while stalling because their operands may come
    // from the pending load.
    always_comb begin
        ev_stall = (state_q == ST_LU_STALL) | lu_hit;
        ev_flush = !ev_stall & bus.branch_taken_i;
        ev_wait  = !ev_stall & !bus.branch_taken_i & !bus.imem_ready_i;
    end

    // State, counter and flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            lu_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_cnt_q    <= lu_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic: sequencing, wait timer, sticky error and counters
    always_comb begin
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            ST_LU_STALL: begin
                // Count down the remaining stall cycles, inputs ignored
                lu_cnt_d = lu_cnt_q - 1'b1;
                if (lu_cnt_q == LU_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // RUN and FETCH_WAIT share the same arbitration
                if (lu_hit) begin
                    wait_cnt_d = '0;
                    if (LOAD_USE_CYCLES > 1) begin
                        state_d  = ST_LU_STALL;
                        lu_cnt_d = LU_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (ev_wait) begin
                    state_d = ST_FETCH_WAIT;
                    if (state_q != ST_FETCH_WAIT) begin
                        wait_cnt_d = WAIT_W'(1);
                    end else if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    // Branch redirect or a good fetch: back to RUN
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
        endcase

        if (ev_wait && (wait_cnt_d >= WAIT_MAX)) begin
            err_d = 1'b1;
        end

        if ((ev_stall || ev_wait) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        if (ev_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Mealy pipeline controls; reset forces a frozen PC and NOPs everywhere
    always_comb begin
        bus.pc_write_o    = 1'b1;
        bus.ifid_hold_o   = 1'b0;
        bus.ifid_branch_o = 2'd0;
        bus.idex_bubble_o = 1'b0;
        if (rst_i) begin
            bus.pc_write_o    = 1'b0;
            bus.ifid_branch_o = 2'd2;
            bus.idex_bubble_o = 1'b1;
        end else if (ev_stall) begin
            bus.pc_write_o    = 1'b0;
            bus.ifid_hold_o   = 1'b1;
            bus.idex_bubble_o = 1'b1;
        end else if (ev_flush) begin
            // PC loads the branch target, wrong-path fetch becomes a NOP
            bus.ifid_branch_o = 2'd2;
        end else if (ev_wait) begin
            // Invalid fetch data becomes a NOP while the PC waits
            bus.pc_write_o    = 1'b0;
            bus.ifid_branch_o = 2'd2;
        end
    end

    assign bus.fetch_err_o = err_q;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances with different parameters
// share one stimulus stream; each is compared every cycle against a
// cycle-level reference model kept in plain integers.
module tb_pipe_hazard_ctrl;

    localparam int N = 3;
    localparam int L_TAB [N] = '{1, 2, 3};
    localparam int T_TAB [N] = '{64, 64, 8};
    localparam int W_TAB [N] = '{16, 16, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use_rs2, memread, br, ready;

    logic [5:0]  obs_ctl   [N];
    logic [15:0] obs_stall [N];
    logic [15:0] obs_flush [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_inst
            pipe_hazard_ctrl_if #(.CNT_W(W_TAB[gi])) u_if ();

            assign u_if.id_rs1_i       = rs1;
            assign u_if.id_rs2_i       = rs2;
            assign u_if.id_use_rs2_i   = use_rs2;
            assign u_if.ex_memread_i   = memread;
            assign u_if.ex_rd_i        = rd;
            assign u_if.branch_taken_i = br;
            assign u_if.imem_ready_i   = ready;

            pipe_hazard_ctrl #(
                .LOAD_USE_CYCLES(L_TAB[gi]),
                .FETCH_TIMEOUT  (T_TAB[gi]),
                .CNT_W          (W_TAB[gi])
            ) u_dut (
                .clk_i(clk),
                .rst_i(rst),
                .bus  (u_if.slave)
            );

            assign obs_ctl[gi]   = {u_if.pc_write_o, u_if.ifid_hold_o, u_if.ifid_branch_o,
                                    u_if.idex_bubble_o, u_if.fetch_err_o};
            assign obs_stall[gi] = 16'(u_if.stall_cnt_o);
            assign obs_flush[gi] = 16'(u_if.flush_cnt_o);
        end
    endgenerate

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: stall cycles still owed, fetch-wait run length
    int m_left    [N];
    int m_wait    [N];
    int m_stall   [N];
    int m_flush   [N];
    bit m_waiting [N];
    bit m_err     [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Evaluate one clock cycle with the inputs currently driven
    task automatic cycle();
        int nl [N];
        int nw [N];
        int ns [N];
        int nf [N];
        bit nwg [N];
        bit ne [N];
        #1;
        for (int k = 0; k < N; k++) begin
            int         lim;
            bit         lu;
            bit         pc, hold, bub;
            logic [1:0] bc;
            logic [5:0] exp_ctl;
            lim    = (1 << W_TAB[k]) - 1;
            lu     = memread && (rd != 0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
            nl[k]  = m_left[k];
            nw[k]  = m_wait[k];
            ns[k]  = m_stall[k];
            nf[k]  = m_flush[k];
            nwg[k] = m_waiting[k];
            ne[k]  = m_err[k];
            if (rst) begin
                pc = 0; hold = 0; bc = 2'd2; bub = 1;
                nl[k] = 0; nw[k] = 0; ns[k] = 0; nf[k] = 0; nwg[k] = 0; ne[k] = 0;
            end else if (m_left[k] > 0 || lu) begin
                pc = 0; hold = 1; bc = 2'd0; bub = 1;
                if (ns[k] < lim) ns[k]++;
                nl[k]  = (m_left[k] > 0) ? m_left[k] - 1 : L_TAB[k] - 1;
                nwg[k] = 0;
                nw[k]  = 0;
            end else if (br) begin
                pc = 1; hold = 0; bc = 2'd2; bub = 0;
                if (nf[k] < lim) nf[k]++;
                nwg[k] = 0;
                nw[k]  = 0;
            end else if (!ready) begin
                pc = 0; hold = 0; bc = 2'd2; bub = 0;
                if (ns[k] < lim) ns[k]++;
                nw[k]  = m_waiting[k] ? ((m_wait[k] < T_TAB[k]) ? m_wait[k] + 1 : T_TAB[k]) : 1;
                nwg[k] = 1;
                if (nw[k] >= T_TAB[k]) ne[k] = 1;
            end else begin
                pc = 1; hold = 0; bc = 2'd0; bub = 0;
                nwg[k] = 0;
                nw[k]  = 0;
            end
            exp_ctl = {pc, hold, bc, bub, m_err[k]};
            check($sformatf("i%0d ctl{pc,hold,br,bub,err}", k), 64'(obs_ctl[k]), 64'(exp_ctl));
            check($sformatf("i%0d stall_cnt", k), 64'(obs_stall[k]), 64'(m_stall[k]));
            check($sformatf("i%0d flush_cnt", k), 64'(obs_flush[k]), 64'(m_flush[k]));
        end
        $display("[TB] c%0d rst=%0b rdy=%0b br=%0b ld=%0b rd=%0d rs1=%0d rs2=%0d/%0b | ctl=%b/%b/%b st=%0d/%0d/%0d fl=%0d/%0d/%0d",
                 cyc, rst, ready, br, memread, rd, rs1, rs2, use_rs2,
                 obs_ctl[0], obs_ctl[1], obs_ctl[2],
                 obs_stall[0], obs_stall[1], obs_stall[2],
                 obs_flush[0], obs_flush[1], obs_flush[2]);
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            m_left[k]    = nl[k];
            m_wait[k]    = nw[k];
            m_stall[k]   = ns[k];
            m_flush[k]   = nf[k];
            m_waiting[k] = nwg[k];
            m_err[k]     = ne[k];
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_idle();
        rst     = 1'b0;
        ready   = 1'b1;
        br      = 1'b0;
        memread = 1'b0;
        rd      = 5'd0;
        rs1     = 5'd1;
        rs2     = 5'd2;
        use_rs2 = 1'b0;
    endtask

    task automatic idle(input int n);
        set_idle();
        repeat (n) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int burst;
        burst = 0;
        for (int k = 0; k < N; k++) begin
            m_left[k] = 0; m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            m_waiting[k] = 0; m_err[k] = 0;
        end

        // Reset, then one checked cycle with reset still asserted
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 1'b0;

        // Straight-line fetch
        idle(10);

        // Load-use on rs1, then x0 destination (no hazard)
        memread = 1; rd = 5'd5; rs1 = 5'd5; cycle();
        idle(4);
        memread = 1; rd = 5'd0; rs1 = 5'd0; cycle();
        idle(3);

        // Load-use via rs2 only when rs2 is used
        memread = 1; rd = 5'd7; rs2 = 5'd7; use_rs2 = 1; cycle();
        use_rs2 = 0; cycle();
        idle(3);

        // Load-use coinciding with a taken branch; branch held during stall
        memread = 1; rd = 5'd5; rs1 = 5'd5; br = 1; cycle();
        memread = 0; cycle(); cycle();
        idle(3);

        // Taken branch while the fetch is not ready
        br = 1; ready = 0; cycle();
        br = 0; cycle(); cycle();
        idle(3);

        // Long fetch wait past the timeout, error stays after ready returns
        set_idle(); ready = 0;
        repeat (70) cycle();
        idle(5);

        // Branch arriving during a fetch wait
        set_idle(); ready = 0; repeat (3) cycle();
        br = 1; cycle();
        br = 0; cycle();
        idle(2);

        // Load-use arriving during a fetch wait
        set_idle(); ready = 0; repeat (2) cycle();
        memread = 1; rd = 5'd9; rs1 = 5'd9; cycle();
        memread = 0; repeat (3) cycle();
        idle(3);

        // Reset in the middle of a multi-cycle load-use stall
        memread = 1; rd = 5'd5; rs1 = 5'd5; cycle();
        set_idle(); rst = 1; cycle();
        idle(4);

        // Randomized traffic with fetch-wait bursts and occasional resets
        for (int i = 0; i < 1200; i++) begin
            rst     = ($urandom_range(0, 149) == 0);
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            rd      = 5'($urandom_range(0, 3));
            use_rs2 = 1'($urandom_range(0, 1));
            memread = ($urandom_range(0, 3) == 0);
            br      = ($urandom_range(0, 6) == 0);
            if (burst > 0) begin
                ready = 1'b0;
                burst--;
            end else begin
                ready = ($urandom_range(0, 9) >= 2);
                if ($urandom_range(0, 49) == 0) burst = $urandom_range(5, 20);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
